// File: rtl/collision_scanner_pkg.sv
// Shared types and geometry defaults for the flappy collision scanner.
package flappy_pkg;

   localparam int DEF_WIDTH     = 10;
   localparam int DEF_HEIGHT    = 10;
   localparam int DEF_NUM_PIPES = 4;
   localparam int DEF_BIRD_HW   = 8;
   localparam int DEF_BIRD_HH   = 8;
   localparam int DEF_PIPE_HW   = 16;
   localparam int DEF_GAP_HH    = 40;
   localparam int DEF_FLOOR_Y   = 440;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_t;

   typedef logic [DEF_WIDTH-1:0]  coord_x_t;
   typedef logic [DEF_HEIGHT-1:0] coord_y_t;

   // Edge arithmetic width is derived from the wider coordinate.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/collision_scanner_if.sv
// Frame-evaluation bus between the game core (master) and the scanner (slave).
interface collision_scanner_if #(
   parameter int WIDTH     = 10,
   parameter int HEIGHT    = 10,
   parameter int NUM_PIPES = 4
);
   localparam int CNT_W = $clog2(NUM_PIPES + 1);

   logic                        frame_tick;
   logic                        clear;
   logic [WIDTH-1:0]            bird_x;
   logic [HEIGHT-1:0]           bird_y;
   logic [NUM_PIPES*WIDTH-1:0]  pipe_x;
   logic [NUM_PIPES*HEIGHT-1:0] gap_y;
   logic [NUM_PIPES-1:0]        pipe_valid;

   logic                        busy;
   logic                        done;
   logic [NUM_PIPES-1:0]        hit_vec;
   logic                        bound_hit;
   logic                        collision;
   logic                        pass_pulse;
   logic [CNT_W-1:0]            pass_count;
   logic                        overrun;

   modport master (
      output frame_tick, clear, bird_x, bird_y, pipe_x, gap_y, pipe_valid,
      input  busy, done, hit_vec, bound_hit, collision, pass_pulse, pass_count, overrun
   );

   modport slave (
      input  frame_tick, clear, bird_x, bird_y, pipe_x, gap_y, pipe_valid,
      output busy, done, hit_vec, bound_hit, collision, pass_pulse, pass_count, overrun
   );
endinterface

// File: rtl/collision_scanner_box_check.sv
// Single-channel bird-vs-pipe AABB compare; purely combinational, shared across channels.
module collision_box_check
   import flappy_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int HEIGHT  = DEF_HEIGHT,
   parameter int BIRD_HW = DEF_BIRD_HW,
   parameter int BIRD_HH = DEF_BIRD_HH,
   parameter int PIPE_HW = DEF_PIPE_HW,
   parameter int GAP_HH  = DEF_GAP_HH
) (
   input  logic [WIDTH-1:0]  bird_x_i,
   input  logic [HEIGHT-1:0] bird_y_i,
   input  logic [WIDTH-1:0]  pipe_x_i,
   input  logic [HEIGHT-1:0] gap_y_i,
   input  logic              valid_i,
   output logic              hit_o,
   output logic              x_overlap_o,
   output logic              past_o
);
   localparam int CW = max_int(WIDTH, HEIGHT) + 2;
   typedef logic signed [CW-1:0] edge_t;

   localparam edge_t BIRD_HW_E = edge_t'(BIRD_HW);
   localparam edge_t BIRD_HH_E = edge_t'(BIRD_HH);
   localparam edge_t PIPE_HW_E = edge_t'(PIPE_HW);
   localparam edge_t GAP_HH_E  = edge_t'(GAP_HH);

   edge_t bx, by, px, gy;
   edge_t bird_l, bird_r, bird_t, bird_b;
   edge_t pipe_l, pipe_r, gap_t, gap_b;
   logic  gap_miss;

   // Zero-extend into a signed domain wide enough that no edge can wrap.
   assign bx = edge_t'({{(CW-WIDTH){1'b0}}, bird_x_i});
   assign by = edge_t'({{(CW-HEIGHT){1'b0}}, bird_y_i});
   assign px = edge_t'({{(CW-WIDTH){1'b0}}, pipe_x_i});
   assign gy = edge_t'({{(CW-HEIGHT){1'b0}}, gap_y_i});

   assign bird_l = bx - BIRD_HW_E;
   assign bird_r = bx + BIRD_HW_E;
   assign bird_t = by - BIRD_HH_E;
   assign bird_b = by + BIRD_HH_E;
   assign pipe_l = px - PIPE_HW_E;
   assign pipe_r = px + PIPE_HW_E;
   assign gap_t  = gy - GAP_HH_E;
   assign gap_b  = gy + GAP_HH_E;

   assign x_overlap_o = (bird_r >= pipe_l) && (bird_l <= pipe_r);
   assign gap_miss    = (bird_t <= gap_t) || (bird_b >= gap_b);
   assign hit_o       = valid_i && x_overlap_o && gap_miss;
   assign past_o      = valid_i && (bird_l > pipe_r);

endmodule

// File: rtl/collision_scanner.sv
// Per-frame collision/score scanner: snapshots positions, walks pipes one per cycle.
//
//   state | meaning
//   IDLE  | waiting for frame_tick (ignored while collision is latched)
//   SCAN  | comparing channel idx_q against the bird, idx 0..NUM_PIPES-1
//   DONE  | results of the frame are on the outputs, done=1
module collision_scanner
   import flappy_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int HEIGHT    = DEF_HEIGHT,
   parameter int NUM_PIPES = DEF_NUM_PIPES,
   parameter int BIRD_HW   = DEF_BIRD_HW,
   parameter int BIRD_HH   = DEF_BIRD_HH,
   parameter int PIPE_HW   = DEF_PIPE_HW,
   parameter int GAP_HH    = DEF_GAP_HH,
   parameter int FLOOR_Y   = DEF_FLOOR_Y
) (
   input logic                clk,
   input logic                reset,
   collision_scanner_if.slave bus
);
   localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
   localparam int CNT_W = $clog2(NUM_PIPES + 1);
   localparam int CW    = max_int(WIDTH, HEIGHT) + 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIPES - 1);

   localparam logic signed [CW-1:0] ZERO_E    = '0;
   localparam logic signed [CW-1:0] BIRD_HH_E = CW'(BIRD_HH);
   localparam logic signed [CW-1:0] FLOOR_E   = CW'(FLOOR_Y);

   scan_state_t                 state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic                        accept;
   logic                        scan_last;

   logic [WIDTH-1:0]            bird_x_q;
   logic [HEIGHT-1:0]           bird_y_q;
   logic [NUM_PIPES*WIDTH-1:0]  pipe_x_q;
   logic [NUM_PIPES*HEIGHT-1:0] gap_y_q;
   logic [NUM_PIPES-1:0]        valid_q;

   logic [NUM_PIPES-1:0]        hit_acc_q, passed_q, hit_vec_q;
   logic [CNT_W-1:0]            cnt_q, pass_count_q;
   logic                        bound_hit_q, collision_q, pass_pulse_q, overrun_q;

   logic [WIDTH-1:0]            sel_pipe_x;
   logic [HEIGHT-1:0]           sel_gap_y;
   logic                        sel_valid;
   logic                        hit_c, xov_c, past_c, bound_c, newly;
   logic [NUM_PIPES-1:0]        hit_next, passed_next;
   logic [CNT_W-1:0]            cnt_next;
   logic signed [CW-1:0]        bird_top, bird_bot;

   assign sel_pipe_x = pipe_x_q[int'(idx_q)*WIDTH +: WIDTH];
   assign sel_gap_y  = gap_y_q[int'(idx_q)*HEIGHT +: HEIGHT];
   assign sel_valid  = valid_q[idx_q];

   collision_box_check #(
      .WIDTH   (WIDTH),
      .HEIGHT  (HEIGHT),
      .BIRD_HW (BIRD_HW),
      .BIRD_HH (BIRD_HH),
      .PIPE_HW (PIPE_HW),
      .GAP_HH  (GAP_HH)
   ) u_box (
      .bird_x_i    (bird_x_q),
      .bird_y_i    (bird_y_q),
      .pipe_x_i    (sel_pipe_x),
      .gap_y_i     (sel_gap_y),
      .valid_i     (sel_valid),
      .hit_o       (hit_c),
      .x_overlap_o (xov_c),
      .past_o      (past_c)
   );

   // A pipe hit can only ever come from a horizontal overlap.
   always_comb begin
      assert (!hit_c || xov_c);
   end

   assign bird_top = $signed({{(CW-HEIGHT){1'b0}}, bird_y_q}) - BIRD_HH_E;
   assign bird_bot = $signed({{(CW-HEIGHT){1'b0}}, bird_y_q}) + BIRD_HH_E;
   assign bound_c  = (bird_top <= ZERO_E) || (bird_bot >= FLOOR_E);

   // Merge the current channel's result into the running frame vectors.
   always_comb begin
      hit_next    = hit_acc_q;
      passed_next = passed_q;
      for (int i = 0; i < NUM_PIPES; i++) begin
         if (IDX_W'(i) == idx_q) begin
            hit_next[i]    = hit_c;
            passed_next[i] = past_c;
         end
      end
      newly    = past_c && !passed_q[idx_q];
      cnt_next = cnt_q + CNT_W'(newly);
   end

   // Next-state logic; clear overrides everything, including a same-cycle tick.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      accept  = 1'b0;
      if (bus.clear) begin
         state_d = IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.frame_tick && !collision_q) begin
                  state_d = SCAN;
                  idx_d   = '0;
                  accept  = 1'b1;
               end
            end
            SCAN: begin
               if (idx_q == LAST_IDX) state_d = DONE;
               else                   idx_d   = idx_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign scan_last = (state_q == SCAN) && (idx_q == LAST_IDX);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Snapshot, per-frame accumulation and result registers; results land on entry to DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bird_x_q     <= '0;
         bird_y_q     <= '0;
         pipe_x_q     <= '0;
         gap_y_q      <= '0;
         valid_q      <= '0;
         hit_acc_q    <= '0;
         passed_q     <= '0;
         hit_vec_q    <= '0;
         cnt_q        <= '0;
         pass_count_q <= '0;
         bound_hit_q  <= 1'b0;
         collision_q  <= 1'b0;
         pass_pulse_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else if (bus.clear) begin
         hit_acc_q    <= '0;
         passed_q     <= '0;
         cnt_q        <= '0;
         pass_count_q <= '0;
         collision_q  <= 1'b0;
         pass_pulse_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         pass_pulse_q <= 1'b0;
         pass_count_q <= '0;
         overrun_q    <= bus.frame_tick && (state_q != IDLE);
         if (accept) begin
            bird_x_q  <= bus.bird_x;
            bird_y_q  <= bus.bird_y;
            pipe_x_q  <= bus.pipe_x;
            gap_y_q   <= bus.gap_y;
            valid_q   <= bus.pipe_valid;
            hit_acc_q <= '0;
            cnt_q     <= '0;
         end
         if (state_q == SCAN) begin
            hit_acc_q <= hit_next;
            passed_q  <= passed_next;
            cnt_q     <= cnt_next;
            if (scan_last) begin
               hit_vec_q   <= hit_next;
               bound_hit_q <= bound_c;
               if ((|hit_next) || bound_c) begin
                  collision_q <= 1'b1;
               end else if (cnt_next != '0) begin
                  pass_pulse_q <= 1'b1;
                  pass_count_q <= cnt_next;
               end
            end
         end
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.hit_vec    = hit_vec_q;
   assign bus.bound_hit  = bound_hit_q;
   assign bus.collision  = collision_q;
   assign bus.pass_pulse = pass_pulse_q;
   assign bus.pass_count = pass_count_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboard bench for collision_scanner with hand-computed directed frames.
module tb_collision_scanner;
   localparam int NP = 4;

   typedef struct {
      logic [3:0] hv;
      logic       bh;
      logic       col;
      logic       pp;
      logic [2:0] pc;
      int         dcyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   done_cnt = 0;
   int   d_mark = 0;
   exp_t sb[$];
   exp_t mon_e;

   collision_scanner_if #(.WIDTH(10), .HEIGHT(10), .NUM_PIPES(NP)) bus ();

   collision_scanner #(.WIDTH(10), .HEIGHT(10), .NUM_PIPES(NP)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Monitor: every done pulse pops one expected frame result.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("done_cycle", cyc, mon_e.dcyc);
            chk("hit_vec", 32'(bus.hit_vec), 32'(mon_e.hv));
            chk("bound_hit", 32'(bus.bound_hit), 32'(mon_e.bh));
            chk("collision", 32'(bus.collision), 32'(mon_e.col));
            chk("pass_pulse", 32'(bus.pass_pulse), 32'(mon_e.pp));
            if (mon_e.pp) chk("pass_count", 32'(bus.pass_count), 32'(mon_e.pc));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_bird(input int x, input int y);
      bus.bird_x = 10'(x);
      bus.bird_y = 10'(y);
   endtask

   task automatic set_pipe(input int ch, input int x, input int g);
      bus.pipe_x[ch*10 +: 10] = 10'(x);
      bus.gap_y[ch*10 +: 10]  = 10'(g);
   endtask

   task automatic start_tick(input logic [3:0] hv, input logic bh, input logic pp, input logic [2:0] pc);
      exp_t e;
      e.hv   = hv;
      e.bh   = bh;
      e.col  = (hv != 4'd0) || bh;
      e.pp   = pp;
      e.pc   = pc;
      e.dcyc = cyc + NP + 1;
      sb.push_back(e);
      d_mark = done_cnt;
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      chk("busy_in_scan", 32'(bus.busy), 32'd1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_cnt == d_mark && n < 20) begin
         step();
         n++;
      end
      chk("done_arrived", 32'(done_cnt != d_mark), 32'd1);
   endtask

   task automatic frame(input logic [3:0] hv, input logic bh, input logic pp, input logic [2:0] pc);
      start_tick(hv, bh, pp, pc);
      wait_done();
      chk("busy_after_done", 32'(bus.busy), 32'd0);
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      chk("collision_cleared", 32'(bus.collision), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      bus.frame_tick = 1'b0;
      bus.clear      = 1'b0;
      bus.bird_x     = '0;
      bus.bird_y     = '0;
      bus.pipe_x     = '0;
      bus.gap_y      = '0;
      bus.pipe_valid = '0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Reset state
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_collision", 32'(bus.collision), 32'd0);
      chk("rst_hit_vec", 32'(bus.hit_vec), 32'd0);
      chk("rst_bound_hit", 32'(bus.bound_hit), 32'd0);
      chk("rst_pass_pulse", 32'(bus.pass_pulse), 32'd0);
      chk("rst_overrun", 32'(bus.overrun), 32'd0);

      // Reset asserted mid-scan
      set_bird(100, 240);
      set_pipe(0, 300, 240);
      bus.pipe_valid = 4'b0001;
      d_mark = done_cnt;
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
      chk("midscan_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(bus.busy), 32'd0);
      chk("async_rst_done", 32'(bus.done), 32'd0);
      chk("async_rst_collision", 32'(bus.collision), 32'd0);
      chk("async_rst_hit_vec", 32'(bus.hit_vec), 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (10) step();
      chk("no_done_after_reset", 32'(done_cnt - d_mark), 32'd0);

      // Clear frame, no contact
      frame(4'b0000, 1'b0, 1'b0, 3'd0);

      // Scoring: pipe1 right edge 186 < bird left 192
      bus.pipe_valid = 4'b0010;
      set_bird(200, 240);
      set_pipe(1, 170, 240);
      frame(4'b0000, 1'b0, 1'b1, 3'd1);
      frame(4'b0000, 1'b0, 1'b0, 3'd0);
      set_pipe(0, 100, 240);
      set_pipe(2, 50, 240);
      set_pipe(3, 20, 240);
      bus.pipe_valid = 4'b1111;
      frame(4'b0000, 1'b0, 1'b1, 3'd3);
      set_pipe(1, 400, 240);
      frame(4'b0000, 1'b0, 1'b0, 3'd0);
      set_pipe(1, 170, 240);
      frame(4'b0000, 1'b0, 1'b1, 3'd1);

      // Tick while scanning
      start_tick(4'b0000, 1'b0, 1'b0, 3'd0);
      step();
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      chk("overrun_busy", 32'(bus.overrun), 32'd1);
      step();
      chk("overrun_one_cycle", 32'(bus.overrun), 32'd0);
      wait_done();
      repeat (6) step();
      chk("done_count_overrun", 32'(done_cnt - d_mark), 32'd1);

      // Tick coinciding with done
      start_tick(4'b0000, 1'b0, 1'b0, 3'd0);
      repeat (4) step();
      chk("done_at_T_plus_5", 32'(bus.done), 32'd1);
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      chk("overrun_at_done", 32'(bus.overrun), 32'd1);
      chk("tick_at_done_dropped", 32'(bus.busy), 32'd0);
      repeat (6) step();
      chk("done_count_at_done", 32'(done_cnt - d_mark), 32'd1);

      // Clear and tick together: no scan; pass bits dropped so all four score again
      d_mark = done_cnt;
      bus.clear      = 1'b1;
      bus.frame_tick = 1'b1;
      step();
      bus.clear      = 1'b0;
      bus.frame_tick = 1'b0;
      chk("clear_tick_busy", 32'(bus.busy), 32'd0);
      repeat (8) step();
      chk("clear_tick_no_done", 32'(done_cnt - d_mark), 32'd0);
      frame(4'b0000, 1'b0, 1'b1, 3'd4);

      // Mask 0: overlapping geometry ignored
      bus.pipe_valid = 4'b0000;
      set_bird(300, 180);
      set_pipe(0, 300, 240);
      frame(4'b0000, 1'b0, 1'b0, 3'd0);

      // Edge boundaries on pipe0 (x 284..316, gap 200..280)
      bus.pipe_valid = 4'b0001;
      set_bird(275, 208);
      frame(4'b0000, 1'b0, 1'b0, 3'd0);
      set_bird(276, 209);
      frame(4'b0000, 1'b0, 1'b0, 3'd0);
      set_bird(276, 208);
      frame(4'b0001, 1'b0, 1'b0, 3'd0);
      do_clear();
      set_bird(324, 272);
      frame(4'b0001, 1'b0, 1'b0, 3'd0);
      do_clear();
      set_bird(325, 240);
      frame(4'b0000, 1'b0, 1'b1, 3'd1);

      // Ceiling and floor
      bus.pipe_valid = 4'b0000;
      set_bird(100, 9);
      frame(4'b0000, 1'b0, 1'b0, 3'd0);
      set_bird(100, 8);
      frame(4'b0000, 1'b1, 1'b0, 3'd0);
      do_clear();
      set_bird(100, 5);
      frame(4'b0000, 1'b1, 1'b0, 3'd0);
      do_clear();
      set_bird(100, 431);
      frame(4'b0000, 1'b0, 1'b0, 3'd0);
      set_bird(100, 432);
      frame(4'b0000, 1'b1, 1'b0, 3'd0);
      do_clear();

      // pipe_x=0: left edge -16 must not wrap
      bus.pipe_valid = 4'b0001;
      set_pipe(0, 0, 240);
      set_bird(10, 180);
      frame(4'b0001, 1'b0, 1'b0, 3'd0);
      do_clear();

      // Hit latches game-over; further ticks ignored
      set_pipe(0, 300, 240);
      set_bird(300, 180);
      frame(4'b0001, 1'b0, 1'b0, 3'd0);
      d_mark = done_cnt;
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      chk("gameover_no_busy", 32'(bus.busy), 32'd0);
      chk("gameover_no_overrun", 32'(bus.overrun), 32'd0);
      repeat (8) step();
      chk("gameover_no_done", 32'(done_cnt - d_mark), 32'd0);
      chk("gameover_collision_held", 32'(bus.collision), 32'd1);
      chk("gameover_hit_vec_held", 32'(bus.hit_vec), 32'd1);
      do_clear();

      // No score in the frame whose collision sets
      bus.pipe_valid = 4'b0011;
      set_pipe(0, 200, 240);
      set_pipe(1, 170, 240);
      set_bird(200, 180);
      frame(4'b0001, 1'b0, 1'b0, 3'd0);
      do_clear();

      repeat (3) step();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
